// File: rtl/instruction_fetch_unit.sv
// Fetch stage: FETCH -> WAIT (imem handshake) -> ISSUE (hold until commit) -> next PC; HALT is terminal.
// Latency: inst_valid two cycles after FETCH entry with zero-wait imem; imem stalls extend WAIT up to TIMEOUT cycles.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16,
  parameter int unsigned CNT_W    = 5
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] inst_o,
  output logic        inst_valid_o,
  output logic [31:0] pc_o,
  input  logic        commit_i,
  input  logic        is_jal_i,
  input  logic        is_jalr_i,
  input  logic        branch_i,
  input  logic        branch_taken_i,
  input  logic [31:0] imm_i,
  input  logic [31:0] alu_result_i,
  input  logic        halt_req_i,
  output logic        halted_o,
  output logic        fault_o
);

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_ISSUE = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      inst_q, inst_d;
  logic             inst_valid_q, inst_valid_d;
  logic             imem_req_q, imem_req_d;
  logic             halted_q, halted_d;
  logic             fault_q, fault_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [31:0]      next_pc;

  always_comb begin
    if (is_jalr_i)                       next_pc = {alu_result_i[31:1], 1'b0};
    else if (is_jal_i)                   next_pc = pc_q + imm_i;
    else if (branch_i && branch_taken_i) next_pc = pc_q + imm_i;
    else                                 next_pc = pc_q + 32'd4;
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    inst_valid_d = inst_valid_q;
    imem_req_d   = imem_req_q;
    halted_d     = halted_q;
    fault_d      = fault_q;
    wait_cnt_d   = wait_cnt_q;
    case (state_q)
      S_FETCH: begin
        if (pc_q[1:0] != 2'b00) begin
          state_d    = S_HALT;
          fault_d    = 1'b1;
          halted_d   = 1'b1;
          imem_req_d = 1'b0;
        end else begin
          state_d    = S_WAIT;
          wait_cnt_d = '0;
          imem_req_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (imem_ready_i) begin
          state_d      = S_ISSUE;
          inst_d       = imem_rdata_i;
          inst_valid_d = 1'b1;
          imem_req_d   = 1'b0;
        end else if (wait_cnt_q == CNT_LAST) begin
          state_d    = S_HALT;
          fault_d    = 1'b1;
          halted_d   = 1'b1;
          imem_req_d = 1'b0;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_ONE;
        end
      end
      S_ISSUE: begin
        if (commit_i) begin
          inst_valid_d = 1'b0;
          if (halt_req_i) begin
            state_d  = S_HALT;
            halted_d = 1'b1;
          end else begin
            state_d    = S_FETCH;
            pc_d       = next_pc;
            // Request is registered, so raise it now unless FETCH will fault on this PC.
            imem_req_d = (next_pc[1:0] == 2'b00);
          end
        end
      end
      default: begin
        imem_req_d   = 1'b0;
        inst_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      inst_q       <= '0;
      inst_valid_q <= 1'b0;
      imem_req_q   <= 1'b0;
      halted_q     <= 1'b0;
      fault_q      <= 1'b0;
      wait_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      imem_req_q   <= imem_req_d;
      halted_q     <= halted_d;
      fault_q      <= fault_d;
      wait_cnt_q   <= wait_cnt_d;
    end
  end

  assign imem_req_o   = imem_req_q;
  assign imem_addr_o  = pc_q;
  assign inst_o       = inst_q;
  assign inst_valid_o = inst_valid_q;
  assign pc_o         = pc_q;
  assign halted_o     = halted_q;
  assign fault_o      = fault_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit; imem returns addr ^ 0xA5A50000.
module tb_instruction_fetch_unit;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ready_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] inst_o;
  logic        inst_valid_o;
  logic [31:0] pc_o;
  logic        commit_i, is_jal_i, is_jalr_i, branch_i, branch_taken_i, halt_req_i;
  logic [31:0] imm_i, alu_result_i;
  logic        halted_o, fault_o;

  int checks = 0;
  int failures = 0;

  instruction_fetch_unit #(.RESET_PC(32'h0), .TIMEOUT(16), .CNT_W(5)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ready_i(imem_ready_i), .imem_rdata_i(imem_rdata_i),
    .inst_o(inst_o), .inst_valid_o(inst_valid_o), .pc_o(pc_o),
    .commit_i(commit_i), .is_jal_i(is_jal_i), .is_jalr_i(is_jalr_i),
    .branch_i(branch_i), .branch_taken_i(branch_taken_i),
    .imm_i(imm_i), .alu_result_i(alu_result_i), .halt_req_i(halt_req_i),
    .halted_o(halted_o), .fault_o(fault_o)
  );

  always #5 clk_i = ~clk_i;
  assign imem_rdata_i = imem_addr_o ^ 32'hA5A5_0000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_commit();
    commit_i = 1'b1;
    step();
    commit_i = 1'b0;
  endtask

  // From FETCH: one cycle to WAIT, one more to ISSUE with zero-wait memory.
  task automatic fetch_two(input string tag, input logic [31:0] exp_pc);
    step();
    chk({tag, "_wait_valid"}, {31'd0, inst_valid_o}, 32'd0);
    chk({tag, "_wait_req"}, {31'd0, imem_req_o}, 32'd1);
    step();
    chk({tag, "_issue_valid"}, {31'd0, inst_valid_o}, 32'd1);
    chk({tag, "_issue_inst"}, inst_o, exp_pc ^ 32'hA5A5_0000);
    chk({tag, "_issue_req"}, {31'd0, imem_req_o}, 32'd0);
  endtask

  task automatic clear_ctrl();
    is_jal_i = 0; is_jalr_i = 0; branch_i = 0; branch_taken_i = 0;
    halt_req_i = 0; imm_i = 0; alu_result_i = 0;
  endtask

  initial begin
    rst_ni = 1'b0; imem_ready_i = 1'b1; commit_i = 1'b0;
    clear_ctrl();
    #12;
    chk("rst_pc", pc_o, 32'h0);
    chk("rst_addr", imem_addr_o, 32'h0);
    chk("rst_inst", inst_o, 32'h0);
    chk("rst_valid", {31'd0, inst_valid_o}, 32'd0);
    chk("rst_flags", {29'd0, imem_req_o, halted_o, fault_o}, 32'd0);
    rst_ni = 1'b1;
    #1;
    chk("rel_req_low", {31'd0, imem_req_o}, 32'd0);

    // Three sequential ALU instructions
    fetch_two("alu0", 32'h0);
    do_commit();
    chk("alu_pc4", pc_o, 32'h4);
    fetch_two("alu4", 32'h4);
    do_commit();
    chk("alu_pc8", pc_o, 32'h8);
    fetch_two("alu8", 32'h8);
    do_commit();
    chk("alu_pc12", pc_o, 32'hC);
    fetch_two("alu12", 32'hC);

    // jal to 0x100, then branch taken / not taken
    is_jal_i = 1; imm_i = 32'h0000_00F4;
    do_commit();
    clear_ctrl();
    chk("jal_pc", pc_o, 32'h100);
    fetch_two("at100a", 32'h100);
    branch_i = 1; branch_taken_i = 1; imm_i = 32'hFFFF_FFF8;
    do_commit();
    clear_ctrl();
    chk("br_taken_pc", pc_o, 32'h0F8);
    fetch_two("at0f8", 32'h0F8);
    is_jal_i = 1; imm_i = 32'h8;
    do_commit();
    clear_ctrl();
    chk("jal_back_pc", pc_o, 32'h100);
    fetch_two("at100b", 32'h100);
    branch_i = 1; branch_taken_i = 0; imm_i = 32'hFFFF_FFF8;
    do_commit();
    clear_ctrl();
    chk("br_not_taken_pc", pc_o, 32'h104);
    fetch_two("at104", 32'h104);

    // PC wrap from 0xFFFFFFFC
    is_jal_i = 1; imm_i = 32'hFFFF_FEF8;
    do_commit();
    clear_ctrl();
    chk("jal_top_pc", pc_o, 32'hFFFF_FFFC);
    fetch_two("attop", 32'hFFFF_FFFC);
    do_commit();
    chk("wrap_pc", pc_o, 32'h0);
    chk("wrap_req", {31'd0, imem_req_o}, 32'd1);
    fetch_two("wrap0", 32'h0);
    chk("wrap_fault", {31'd0, fault_o}, 32'd0);

    // imem timeout: 16 WAIT cycles with no ready
    do_commit();
    chk("to_pc", pc_o, 32'h4);
    imem_ready_i = 1'b0;
    step();
    for (int i = 0; i < 15; i++) step();
    chk("to_16th_req", {31'd0, imem_req_o}, 32'd1);
    chk("to_16th_fault", {31'd0, fault_o}, 32'd0);
    step();
    chk("to_fault", {31'd0, fault_o}, 32'd1);
    chk("to_halted", {31'd0, halted_o}, 32'd1);
    chk("to_req", {31'd0, imem_req_o}, 32'd0);
    imem_ready_i = 1'b1;
    do_commit();
    chk("to_sticky", {30'd0, fault_o, imem_req_o}, 32'd2);

    // Async reset mid-cycle, then reset mid-WAIT
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_pc", pc_o, 32'h0);
    chk("arst_fault", {30'd0, fault_o, halted_o}, 32'd0);
    step();
    rst_ni = 1'b1; imem_ready_i = 1'b0;
    step();
    chk("mw_req", {31'd0, imem_req_o}, 32'd1);
    #2 rst_ni = 1'b0;
    #1;
    chk("mw_req_drop", {31'd0, imem_req_o}, 32'd0);
    chk("mw_pc", pc_o, 32'h0);
    imem_ready_i = 1'b1;
    step();
    chk("mw_late_ready", {30'd0, inst_valid_o, imem_req_o}, 32'd0);

    // jalr with both jal/jalr set: jalr wins, bit0 cleared, misaligned -> fault
    rst_ni = 1'b1;
    fetch_two("jr0", 32'h0);
    is_jalr_i = 1; is_jal_i = 1; imm_i = 32'h40; alu_result_i = 32'h0000_2003;
    do_commit();
    clear_ctrl();
    chk("jalr_pc", pc_o, 32'h0000_2002);
    chk("jalr_no_req", {31'd0, imem_req_o}, 32'd0);
    chk("jalr_fault_pending", {31'd0, fault_o}, 32'd0);
    step();
    chk("mis_fault", {30'd0, fault_o, halted_o}, 32'd3);
    chk("mis_req", {31'd0, imem_req_o}, 32'd0);
    step();
    chk("mis_req_hold", {31'd0, imem_req_o}, 32'd0);

    // halt_req on commit; commits in WAIT and in HALT are ignored
    rst_ni = 1'b0;
    step();
    rst_ni = 1'b1; imem_ready_i = 1'b0;
    step();
    do_commit();
    chk("wait_commit_pc", pc_o, 32'h0);
    chk("wait_commit_valid", {31'd0, inst_valid_o}, 32'd0);
    imem_ready_i = 1'b1;
    step();
    chk("h_issue_valid", {31'd0, inst_valid_o}, 32'd1);
    halt_req_i = 1;
    do_commit();
    clear_ctrl();
    chk("halt_halted", {30'd0, halted_o, fault_o}, 32'd2);
    chk("halt_pc", pc_o, 32'h0);
    chk("halt_valid", {31'd0, inst_valid_o}, 32'd0);
    do_commit();
    step();
    chk("halt_ign_pc", pc_o, 32'h0);
    chk("halt_ign_req", {30'd0, imem_req_o, halted_o}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
